// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing stage and the iterative multiply/divide unit.
// The issuing stage drives the request side; the unit drives the handshake replies.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] operand_A;
   logic [XLEN-1:0] operand_B;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output flush, in_valid, op, operand_A, operand_B, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  flush, in_valid, op, operand_A, operand_B, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MUL/MULHU and restoring DIVU/REMU.
// Each operation takes 32 iterations; the result is registered in the first DONE cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r;
   logic [1:0]        op_r;
   logic [XLEN-1:0]   a_r;
   logic [XLEN-1:0]   b_r;
   logic [2*XLEN-1:0] acc_r;
   logic [XLEN-1:0]   rem_r;
   logic [4:0]        cnt_r;
   logic              out_valid_r;
   logic [XLEN-1:0]   result_r;

   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     div_shift_s;
   logic [XLEN-1:0]   div_diff_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   done_res_s;

   // One datapath step for each algorithm, plus the result selection for DONE.
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, a_r} : 33'd0);
      div_shift_s = {rem_r, acc_r[XLEN-1]};
      div_ge_s    = (div_shift_s >= {1'b0, b_r});
      // The difference is smaller than the divisor whenever it is kept, so 32 bits suffice.
      div_diff_s  = div_shift_s[XLEN-1:0] - b_r;
      case (op_r)
         2'b00:   done_res_s = acc_r[XLEN-1:0];
         2'b01:   done_res_s = acc_r[2*XLEN-1:XLEN];
         2'b10:   done_res_s = acc_r[XLEN-1:0];
         2'b11:   done_res_s = rem_r;
         default: done_res_s = 32'd0;
      endcase
   end

   // Control FSM with operand latches, iteration state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_r        <= 2'b00;
         a_r         <= 32'd0;
         b_r         <= 32'd0;
         acc_r       <= 64'd0;
         rem_r       <= 32'd0;
         cnt_r       <= 5'd0;
         out_valid_r <= 1'b0;
         result_r    <= 32'd0;
      end else if (bus.flush) begin
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  op_r  <= bus.op;
                  a_r   <= bus.operand_A;
                  b_r   <= bus.operand_B;
                  cnt_r <= 5'd0;
                  if (bus.op[1] && (bus.operand_B == 32'd0)) begin
                     // Divide by zero: preload the architected answers and go straight to DONE.
                     acc_r   <= {32'd0, 32'hFFFF_FFFF};
                     rem_r   <= bus.operand_A;
                     state_r <= DONE;
                  end else begin
                     acc_r   <= bus.op[1] ? {32'd0, bus.operand_A} : {32'd0, bus.operand_B};
                     rem_r   <= 32'd0;
                     state_r <= CALC;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (op_r[1]) begin
                  acc_r[XLEN-1:0] <= {acc_r[XLEN-2:0], div_ge_s};
                  rem_r           <= div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
               end else begin
                  acc_r <= {mul_sum_s, acc_r[XLEN-1:1]};
               end
               if (cnt_r == 5'd31) begin
                  state_r <= DONE;
               end else begin
                  cnt_r <= cnt_r + 5'd1;
               end
            end
            DONE: begin
               if (!out_valid_r) begin
                  result_r    <= done_res_s;
                  out_valid_r <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_r == IDLE) && !bus.flush;
   assign bus.busy      = (state_r != IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, hold, flush and reset behaviour.
module tb_muldiv_unit;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   muldiv_if #(.XLEN(32)) ifc ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string name);
      int cyc;
      @(negedge clk);
      ifc.in_valid  = 1'b1;
      ifc.op        = o;
      ifc.operand_A = a;
      ifc.operand_B = b;
      #1;
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_in_ready: got %b expected 1", name, ifc.in_ready);
      end
      @(posedge clk);
      #1;
      ifc.in_valid  = 1'b0;
      ifc.operand_A = ~a;
      ifc.operand_B = 32'h0000_0001;
      ifc.op        = ~o;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (ifc.out_valid !== 1'b1 && cyc < 100);
      checks++;
      if (cyc !== exp_lat) begin
         errors++;
         $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat);
      end
      checks++;
      if (ifc.result !== exp_res) begin
         errors++;
         $display("FAIL %s_result: got %h expected %h", name, ifc.result, exp_res);
      end
      if (ifc.out_ready === 1'b1) begin
         @(posedge clk);
         #1;
         checks++;
         if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got out_valid=%b busy=%b expected 0 0",
                     name, ifc.out_valid, ifc.busy);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.op = 2'b00;
      ifc.operand_A = 32'd0; ifc.operand_B = 32'd0; ifc.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ifc.out_valid, ifc.busy, ifc.in_ready} !== 3'b001 || ifc.result !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: got ov=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
                  ifc.out_valid, ifc.busy, ifc.in_ready, ifc.result);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33, "mul");
      run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 33, "mulhu_small");
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_max");
   endtask

   task automatic test_div();
      run_op(2'b10, 32'd100, 32'd7, 32'd14, 33, "divu");
      run_op(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu");
      run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_by1");
      run_op(2'b11, 32'd7, 32'd9, 32'd7, 33, "remu_small");
   endtask

   task automatic test_div_zero();
      run_op(2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero");
      run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "remu_zero");
   endtask

   task automatic test_hold();
      ifc.out_ready = 1'b0;
      run_op(2'b10, 32'd100, 32'd7, 32'd14, 33, "hold_op");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (ifc.out_valid !== 1'b1 || ifc.result !== 32'd14 || ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: got ov=%b res=%h rdy=%b expected 1 0000000e 0",
                     i, ifc.out_valid, ifc.result, ifc.in_ready);
         end
      end
      @(negedge clk);
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got ov=%b busy=%b rdy=%b expected 0 0 1",
                  ifc.out_valid, ifc.busy, ifc.in_ready);
      end
   endtask

   task automatic test_flush();
      bit seen;
      int cyc;
      @(negedge clk);
      ifc.in_valid = 1'b1; ifc.op = 2'b00; ifc.operand_A = 32'd5; ifc.operand_B = 32'd6;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      ifc.flush = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_calc: got busy=%b ov=%b expected 0 0", ifc.busy, ifc.out_valid);
      end
      ifc.flush = 1'b0;
      #1;
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got %b expected 1", ifc.in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ifc.out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_result: got out_valid pulse, expected none");
      end
      // Flush together with a request in IDLE must not accept it.
      @(negedge clk);
      ifc.flush = 1'b1; ifc.in_valid = 1'b1; ifc.op = 2'b10; ifc.operand_B = 32'd0;
      @(posedge clk);
      #1;
      ifc.flush = 1'b0; ifc.in_valid = 1'b0;
      checks++;
      if (ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_accept: got busy=%b expected 0", ifc.busy);
      end
      // Flush with out_ready in DONE drops the result.
      ifc.out_ready = 1'b0;
      @(negedge clk);
      ifc.in_valid = 1'b1; ifc.op = 2'b10; ifc.operand_A = 32'd9; ifc.operand_B = 32'd0;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      cyc = 0;
      while (ifc.out_valid !== 1'b1 && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      @(negedge clk);
      ifc.flush = 1'b1; ifc.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc.flush = 1'b0;
      checks++;
      if (cyc !== 1 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_done: got cyc=%0d ov=%b busy=%b expected 1 0 0",
                  cyc, ifc.out_valid, ifc.busy);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      ifc.in_valid = 1'b1; ifc.op = 2'b00; ifc.operand_A = 32'd77; ifc.operand_B = 32'd88;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ifc.out_valid, ifc.busy, ifc.in_ready} !== 3'b001 || ifc.result !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got ov=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
                  ifc.out_valid, ifc.busy, ifc.in_ready, ifc.result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (ifc.out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pulse: got out_valid pulse after release, expected none");
      end
      run_op(2'b00, 32'd3, 32'd4, 32'd12, 33, "mul_after_reset");
   endtask

   task automatic test_back_to_back();
      run_op(2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33, "b2b_mul");
      run_op(2'b10, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 33, "b2b_divu");
      run_op(2'b11, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_BEEF, 33, "b2b_remu");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_hold();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
